// File: rtl/draw_player_sprite_if.sv
// Player image ROM port: requester drives address and frame index, ROM returns pixel data.
interface draw_player_sprite_if;
  localparam int unsigned AW = 15;
  localparam int unsigned SW = 2;
  localparam int unsigned RW = 12;

  logic [AW-1:0] rom_addr;
  logic [SW-1:0] rom_state;
  logic [RW-1:0] rom_rgb;

  modport master (output rom_addr, output rom_state, input rom_rgb);
  modport slave  (input rom_addr, input rom_state, output rom_rgb);
endinterface

// File: rtl/draw_player_sprite.sv
// Player sprite overlay: addresses the player image ROM for the sprite box, animates the
// walk frames once per video frame and merges ROM pixels over the background stream.
module draw_player_sprite #(
  parameter int unsigned IMG_W      = 140,
  parameter int unsigned IMG_H      = 151,
  parameter int unsigned NUM_FRAMES = 3,
  parameter int unsigned FRAME_HOLD = 8,
  parameter logic [11:0] KEY_RGB    = 12'hF0F
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [10:0]                 hcount,
  input  logic [10:0]                 vcount,
  input  logic                        hsync,
  input  logic                        vsync,
  input  logic                        hblnk,
  input  logic                        vblnk,
  input  logic [11:0]                 rgb_in,
  input  logic [10:0]                 xpos,
  input  logic [10:0]                 ypos,
  input  logic                        anim_en,
  draw_player_sprite_if.master        rom,
  output logic [10:0]                 hcount_out,
  output logic [10:0]                 vcount_out,
  output logic                        hsync_out,
  output logic                        vsync_out,
  output logic                        hblnk_out,
  output logic                        vblnk_out,
  output logic [11:0]                 rgb_out
);

  localparam int unsigned CW = 11;            // screen coordinate width
  localparam int unsigned PW = 12;            // compare width, one bit wider than coords
  localparam int unsigned AW = 15;            // ROM address width
  localparam int unsigned SW = 2;             // frame index width
  localparam int unsigned HW = 8;             // hold counter width
  localparam int unsigned RW = 12;            // pixel colour width
  localparam int unsigned TW = 2 * CW + 4;    // timing bundle width

  localparam logic [HW-1:0] HOLD_LAST  = HW'(FRAME_HOLD - 1);
  localparam logic [SW-1:0] FRAME_LAST = SW'(NUM_FRAMES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    WALK = 1'b1
  } anim_state_t;

  // Frame boundary tracking and position latch
  logic          vblnk_prev;
  logic          boundary_c;
  logic [CW-1:0] x_lat;
  logic [CW-1:0] y_lat;

  // Animation state
  anim_state_t   anim_state;
  logic [HW-1:0] hold_cnt;
  logic [SW-1:0] frame_idx;

  // Stage 1 combinational geometry
  logic [PW-1:0] hc_c;
  logic [PW-1:0] vc_c;
  logic [PW-1:0] x_c;
  logic [PW-1:0] y_c;
  logic [PW-1:0] x_end_c;
  logic [PW-1:0] y_end_c;
  logic [PW-1:0] dx_c;
  logic [PW-1:0] dy_c;
  logic          in_box_c;
  logic [AW-1:0] addr_c;
  logic [TW-1:0] timing_c;

  // Pipeline registers
  logic [AW-1:0] rom_addr_q;
  logic          in_box_s1;
  logic          in_box_s2;
  logic [RW-1:0] rgb_s1;
  logic [RW-1:0] rgb_s2;
  logic [TW-1:0] timing_s1;
  logic [TW-1:0] timing_s2;
  logic          blank_s2_c;

  assign boundary_c = vblnk & ~vblnk_prev;

  // Latch the sprite position only on the rising edge of vblnk to avoid mid-frame tearing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_prev <= 1'b0;
      x_lat      <= '0;
      y_lat      <= '0;
    end else begin
      vblnk_prev <= vblnk;
      if (boundary_c) begin
        x_lat <= xpos;
        y_lat <= ypos;
      end
    end
  end

  // Walk animation: advances one step per frame boundary, frame index wraps at NUM_FRAMES
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anim_state <= IDLE;
      hold_cnt   <= '0;
      frame_idx  <= '0;
    end else if (boundary_c) begin
      if (anim_state == IDLE) begin
        if (anim_en) begin
          anim_state <= WALK;
          hold_cnt   <= '0;
          frame_idx  <= '0;
        end
      end else begin
        if (!anim_en) begin
          anim_state <= IDLE;
          hold_cnt   <= '0;
          frame_idx  <= '0;
        end else if (hold_cnt == HOLD_LAST) begin
          hold_cnt  <= '0;
          frame_idx <= (frame_idx == FRAME_LAST) ? '0 : frame_idx + SW'(1);
        end else begin
          hold_cnt <= hold_cnt + HW'(1);
        end
      end
    end
  end

  // Box test in 12 bits so boxes near the right/bottom edge clip instead of wrapping
  assign hc_c     = PW'(hcount);
  assign vc_c     = PW'(vcount);
  assign x_c      = PW'(x_lat);
  assign y_c      = PW'(y_lat);
  assign x_end_c  = x_c + PW'(IMG_W);
  assign y_end_c  = y_c + PW'(IMG_H);
  assign dx_c     = hc_c - x_c;
  assign dy_c     = vc_c - y_c;
  assign in_box_c = (hc_c >= x_c) && (hc_c < x_end_c) &&
                    (vc_c >= y_c) && (vc_c < y_end_c);
  // Inside the box dy < IMG_H and dx < IMG_W, so the product fits the address width
  assign addr_c   = in_box_c ? (AW'(dy_c) * AW'(IMG_W) + AW'(dx_c)) : '0;
  assign timing_c = {hcount, vcount, hsync, vsync, hblnk, vblnk};

  // Stage 1: ROM address plus the side-band carried alongside it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_q <= '0;
      in_box_s1  <= 1'b0;
      rgb_s1     <= '0;
      timing_s1  <= '0;
    end else begin
      rom_addr_q <= addr_c;
      in_box_s1  <= in_box_c;
      rgb_s1     <= rgb_in;
      timing_s1  <= timing_c;
    end
  end

  // Stage 2: wait for the ROM to return data for the stage-1 address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_box_s2 <= 1'b0;
      rgb_s2    <= '0;
      timing_s2 <= '0;
    end else begin
      in_box_s2 <= in_box_s1;
      rgb_s2    <= rgb_s1;
      timing_s2 <= timing_s1;
    end
  end

  assign blank_s2_c = timing_s2[1] | timing_s2[0];

  // Stage 3: merge sprite over background with key-colour transparency and blanking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} <= timing_s2;
      if (blank_s2_c) begin
        rgb_out <= '0;
      end else if (in_box_s2 && (rom.rom_rgb != KEY_RGB)) begin
        rgb_out <= rom.rom_rgb;
      end else begin
        rgb_out <= rgb_s2;
      end
    end
  end

  assign rom.rom_addr  = rom_addr_q;
  assign rom.rom_state = frame_idx;

endmodule
